// File: rtl/sap_pkg.sv
// Shared definitions for the SAP-1.5 control path: opcodes, T-state
// encodings and bit positions inside the microsequencer control word.
package sap_pkg;

  localparam int OPCODE_W = 4;
  localparam int STEP_W   = 3;

  typedef enum logic [STEP_W-1:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } step_e;

  localparam logic [OPCODE_W-1:0] OP_NOP = 4'h0;
  localparam logic [OPCODE_W-1:0] OP_LDA = 4'h1;
  localparam logic [OPCODE_W-1:0] OP_LDB = 4'h2;
  localparam logic [OPCODE_W-1:0] OP_ADD = 4'h3;
  localparam logic [OPCODE_W-1:0] OP_SUB = 4'h4;
  localparam logic [OPCODE_W-1:0] OP_STA = 4'h5;
  localparam logic [OPCODE_W-1:0] OP_LDI = 4'h6;
  localparam logic [OPCODE_W-1:0] OP_JMP = 4'h7;
  localparam logic [OPCODE_W-1:0] OP_JC  = 4'h8;
  localparam logic [OPCODE_W-1:0] OP_JZ  = 4'h9;
  localparam logic [OPCODE_W-1:0] OP_OUT = 4'hE;
  localparam logic [OPCODE_W-1:0] OP_HLT = 4'hF;

  localparam int CW_ENABLE_PC   = 0;
  localparam int CW_ENABLE_IR   = 1;
  localparam int CW_ENABLE_A    = 2;
  localparam int CW_ENABLE_ALU  = 3;
  localparam int CW_OE_RAM      = 4;
  localparam int CW_LOAD_MAR    = 5;
  localparam int CW_LOAD_IR     = 6;
  localparam int CW_LOAD_A      = 7;
  localparam int CW_LOAD_B      = 8;
  localparam int CW_LOAD_OUT    = 9;
  localparam int CW_LOAD_PC     = 10;
  localparam int CW_INC_PC      = 11;
  localparam int CW_WE_RAM      = 12;
  localparam int CW_SUBTRACT    = 13;
  localparam int CW_FLAG_ENABLE = 14;
  localparam int CW_W           = 15;

  function automatic logic [CW_W-1:0] cw(input int idx);
    return (CW_W)'(1) << idx;
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational microcode: (step, opcode, flags) -> control word, plus
// whether this step ends the instruction or enters HALT.
module instr_decode
  import sap_pkg::*;
(
  input  logic [STEP_W-1:0]   step,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                flag_zero,
  input  logic                flag_carry,
  output logic [CW_W-1:0]     ctrl,
  output logic                last_step,
  output logic                halt_req
);

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    ctrl      = '0;
    last_step = 1'b0;
    halt_req  = 1'b0;
    case (step)
      T0: ctrl = cw(CW_ENABLE_PC) | cw(CW_LOAD_MAR);
      T1: ctrl = cw(CW_OE_RAM) | cw(CW_LOAD_IR) | cw(CW_INC_PC);
      T2: begin
        case (opcode)
          OP_LDA, OP_LDB, OP_ADD, OP_SUB, OP_STA:
            ctrl = cw(CW_ENABLE_IR) | cw(CW_LOAD_MAR);
          OP_LDI: begin
            ctrl      = cw(CW_ENABLE_IR) | cw(CW_LOAD_A);
            last_step = 1'b1;
          end
          OP_JMP: begin
            ctrl      = cw(CW_ENABLE_IR) | cw(CW_LOAD_PC);
            last_step = 1'b1;
          end
          OP_JC: begin
            if (flag_carry) ctrl = cw(CW_ENABLE_IR) | cw(CW_LOAD_PC);
            last_step = 1'b1;
          end
          OP_JZ: begin
            if (flag_zero) ctrl = cw(CW_ENABLE_IR) | cw(CW_LOAD_PC);
            last_step = 1'b1;
          end
          OP_OUT: begin
            ctrl      = cw(CW_ENABLE_A) | cw(CW_LOAD_OUT);
            last_step = 1'b1;
          end
          OP_HLT:  halt_req  = 1'b1;
          default: last_step = 1'b1;  // NOP and the undefined A-D
        endcase
      end
      T3: begin
        case (opcode)
          OP_LDA: begin
            ctrl      = cw(CW_OE_RAM) | cw(CW_LOAD_A);
            last_step = 1'b1;
          end
          OP_LDB: begin
            ctrl      = cw(CW_OE_RAM) | cw(CW_LOAD_B);
            last_step = 1'b1;
          end
          OP_ADD, OP_SUB: ctrl = cw(CW_OE_RAM) | cw(CW_LOAD_B);
          OP_STA: begin
            ctrl      = cw(CW_ENABLE_A) | cw(CW_WE_RAM);
            last_step = 1'b1;
          end
          default: last_step = 1'b1;
        endcase
      end
      T4: begin
        // Only ADD/SUB reach T4; this is the sole step that updates flags.
        ctrl = cw(CW_ENABLE_ALU) | cw(CW_LOAD_A) | cw(CW_FLAG_ENABLE);
        if (opcode == OP_SUB) ctrl = ctrl | cw(CW_SUBTRACT);
        last_step = 1'b1;
      end
      default: last_step = 1'b1;
    endcase
  end

endmodule

// File: rtl/microsequencer.sv
// SAP-1.5 control unit: T-state counter and halt bit, with the control
// word decoded combinationally and masked while in reset or HALT.
module microsequencer #(
  parameter int OPCODE_W = 4,
  parameter int STEP_W   = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                flag_zero,
  input  logic                flag_carry,
  output logic                enable_pc,
  output logic                enable_ir,
  output logic                enable_a,
  output logic                enable_alu,
  output logic                oe_ram,
  output logic                load_mar,
  output logic                load_ir,
  output logic                load_a,
  output logic                load_b,
  output logic                load_out,
  output logic                load_pc,
  output logic                inc_pc,
  output logic                we_ram,
  output logic                subtract,
  output logic                flag_enable,
  output logic                halted,
  output logic [STEP_W-1:0]   t_state
);
  import sap_pkg::CW_W, sap_pkg::T0, sap_pkg::cw;
  import sap_pkg::CW_ENABLE_PC, sap_pkg::CW_ENABLE_IR, sap_pkg::CW_ENABLE_A;
  import sap_pkg::CW_ENABLE_ALU, sap_pkg::CW_OE_RAM, sap_pkg::CW_LOAD_MAR;
  import sap_pkg::CW_LOAD_IR, sap_pkg::CW_LOAD_A, sap_pkg::CW_LOAD_B;
  import sap_pkg::CW_LOAD_OUT, sap_pkg::CW_LOAD_PC, sap_pkg::CW_INC_PC;
  import sap_pkg::CW_WE_RAM, sap_pkg::CW_SUBTRACT, sap_pkg::CW_FLAG_ENABLE;

  logic [STEP_W-1:0] step_q, step_d;
  logic              halted_q, halted_d;
  logic [CW_W-1:0]   ctrl_raw, ctrl;
  logic              last_step, halt_req;

  instr_decode u_decode (
    .step       (step_q),
    .opcode     (opcode),
    .flag_zero  (flag_zero),
    .flag_carry (flag_carry),
    .ctrl       (ctrl_raw),
    .last_step  (last_step),
    .halt_req   (halt_req)
  );

  always_comb begin
    step_d   = step_q;
    halted_d = halted_q;
    if (!halted_q) begin
      if (halt_req)       halted_d = 1'b1;  // step stays at T2 while halted
      else if (last_step) step_d   = T0;
      else                step_d   = step_q + (STEP_W)'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_q   <= T0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  // Masking with the raw reset input drops strobes without waiting for an edge.
  assign ctrl = (reset || halted_q) ? '0 : ctrl_raw;

  assign enable_pc   = ctrl[CW_ENABLE_PC];
  assign enable_ir   = ctrl[CW_ENABLE_IR];
  assign enable_a    = ctrl[CW_ENABLE_A];
  assign enable_alu  = ctrl[CW_ENABLE_ALU];
  assign oe_ram      = ctrl[CW_OE_RAM];
  assign load_mar    = ctrl[CW_LOAD_MAR];
  assign load_ir     = ctrl[CW_LOAD_IR];
  assign load_a      = ctrl[CW_LOAD_A];
  assign load_b      = ctrl[CW_LOAD_B];
  assign load_out    = ctrl[CW_LOAD_OUT];
  assign load_pc     = ctrl[CW_LOAD_PC];
  assign inc_pc      = ctrl[CW_INC_PC];
  assign we_ram      = ctrl[CW_WE_RAM];
  assign subtract    = ctrl[CW_SUBTRACT];
  assign flag_enable = ctrl[CW_FLAG_ENABLE];
  assign halted      = halted_q;
  assign t_state     = step_q;

endmodule

// File: tb/tb_microsequencer.sv
// Self-checking bench: per-instruction expectation table feeding a per-cycle
// scoreboard, plus hand-written HALT and asynchronous-reset sequences.
module tb_microsequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic       flag_zero = 1'b0, flag_carry = 1'b0;
  logic enable_pc, enable_ir, enable_a, enable_alu, oe_ram;
  logic load_mar, load_ir, load_a, load_b, load_out, load_pc;
  logic inc_pc, we_ram, subtract, flag_enable, halted;
  logic [2:0] t_state;

  microsequencer dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .flag_zero(flag_zero), .flag_carry(flag_carry),
    .enable_pc(enable_pc), .enable_ir(enable_ir), .enable_a(enable_a),
    .enable_alu(enable_alu), .oe_ram(oe_ram), .load_mar(load_mar),
    .load_ir(load_ir), .load_a(load_a), .load_b(load_b), .load_out(load_out),
    .load_pc(load_pc), .inc_pc(inc_pc), .we_ram(we_ram), .subtract(subtract),
    .flag_enable(flag_enable), .halted(halted), .t_state(t_state)
  );

  always #5 clk = ~clk;

  // Bench-local control word layout, MSB first.
  localparam logic [14:0] C_EPC  = 15'h4000, C_EIR  = 15'h2000, C_EA   = 15'h1000;
  localparam logic [14:0] C_EALU = 15'h0800, C_ORAM = 15'h0400, C_LMAR = 15'h0200;
  localparam logic [14:0] C_LIR  = 15'h0100, C_LA   = 15'h0080, C_LB   = 15'h0040;
  localparam logic [14:0] C_LOUT = 15'h0020, C_LPC  = 15'h0010, C_INC  = 15'h0008;
  localparam logic [14:0] C_WE   = 15'h0004, C_SUB  = 15'h0002, C_FE   = 15'h0001;
  localparam logic [14:0] F0 = C_EPC | C_LMAR;
  localparam logic [14:0] F1 = C_ORAM | C_LIR | C_INC;

  typedef struct {
    logic [3:0]  op;
    logic        zf;
    logic        cf;
    int          len;
    logic [14:0] w2, w3, w4;
  } vec_t;

  typedef struct {
    logic [18:0] val;  // {t_state, halted, control word}
    string       tag;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [14:0] word_now();
    return {enable_pc, enable_ir, enable_a, enable_alu, oe_ram, load_mar, load_ir,
            load_a, load_b, load_out, load_pc, inc_pc, we_ram, subtract, flag_enable};
  endfunction

  // Per-cycle monitor on the falling edge: bus exclusivity plus scoreboard pop.
  always @(negedge clk) begin
    check("bus_onehot0", 32'($onehot0({enable_pc, enable_ir, enable_a, enable_alu, oe_ram})), 32'd1);
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check(e.tag, 32'({t_state, halted, word_now()}), 32'(e.val));
    end
  end

  task automatic push(input logic [2:0] t, input logic h, input logic [14:0] w, input string tag);
    exp_t e;
    e.val = {t, h, w};
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic run_vec(input int idx);
    vec_t  v;
    string tag;
    v   = vecs[idx];
    tag = $sformatf("op%h_z%0d_c%0d", v.op, v.zf, v.cf);
    for (int s = 0; s < v.len; s++) begin
      logic [14:0] w;
      case (s)
        0:       w = F0;
        1:       w = F1;
        2:       w = v.w2;
        3:       w = v.w3;
        default: w = v.w4;
      endcase
      push(3'(s), 1'b0, w, $sformatf("%s_T%0d", tag, s));
    end
    opcode     = v.op;
    flag_zero  = v.zf;
    flag_carry = v.cf;
    repeat (v.len) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{4'h0, 1'b0, 1'b0, 3, 15'h0, 15'h0, 15'h0};
    vecs[1]  = '{4'h1, 1'b0, 1'b0, 4, C_EIR | C_LMAR, C_ORAM | C_LA, 15'h0};
    vecs[2]  = '{4'h2, 1'b0, 1'b0, 4, C_EIR | C_LMAR, C_ORAM | C_LB, 15'h0};
    vecs[3]  = '{4'h3, 1'b0, 1'b0, 5, C_EIR | C_LMAR, C_ORAM | C_LB, C_EALU | C_LA | C_FE};
    vecs[4]  = '{4'h4, 1'b0, 1'b0, 5, C_EIR | C_LMAR, C_ORAM | C_LB, C_EALU | C_LA | C_FE | C_SUB};
    vecs[5]  = '{4'h5, 1'b0, 1'b0, 4, C_EIR | C_LMAR, C_EA | C_WE, 15'h0};
    vecs[6]  = '{4'h6, 1'b0, 1'b0, 3, C_EIR | C_LA, 15'h0, 15'h0};
    vecs[7]  = '{4'h7, 1'b0, 1'b0, 3, C_EIR | C_LPC, 15'h0, 15'h0};
    vecs[8]  = '{4'h8, 1'b1, 1'b0, 3, 15'h0, 15'h0, 15'h0};
    vecs[9]  = '{4'h8, 1'b0, 1'b1, 3, C_EIR | C_LPC, 15'h0, 15'h0};
    vecs[10] = '{4'h9, 1'b0, 1'b1, 3, 15'h0, 15'h0, 15'h0};
    vecs[11] = '{4'h9, 1'b1, 1'b0, 3, C_EIR | C_LPC, 15'h0, 15'h0};
    vecs[12] = '{4'hE, 1'b0, 1'b0, 3, C_EA | C_LOUT, 15'h0, 15'h0};
    vecs[13] = '{4'hA, 1'b1, 1'b1, 3, 15'h0, 15'h0, 15'h0};
    vecs[14] = '{4'hB, 1'b0, 1'b1, 3, 15'h0, 15'h0, 15'h0};
    vecs[15] = '{4'hC, 1'b1, 1'b0, 3, 15'h0, 15'h0, 15'h0};
    vecs[16] = '{4'hD, 1'b0, 1'b0, 3, 15'h0, 15'h0, 15'h0};
    vecs[17] = '{4'h0, 1'b1, 1'b1, 3, 15'h0, 15'h0, 15'h0};
    vecs[18] = '{4'h8, 1'b1, 1'b1, 3, C_EIR | C_LPC, 15'h0, 15'h0};
    vecs[19] = '{4'h9, 1'b1, 1'b1, 3, C_EIR | C_LPC, 15'h0, 15'h0};

    // Reset state, observed before any clock edge.
    #1 reset = 1'b1;
    #2;
    check("rst_ctrl", 32'(word_now()), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_tstate", 32'(t_state), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 20; i++) run_vec(i);

    for (int n = 0; n < 1000; n++) run_vec(int'($urandom_range(0, 19)));

    // HLT: halts from cycle 3 with t_state parked at 2 and no strobes.
    push(3'd0, 1'b0, F0, "hlt_T0");
    push(3'd1, 1'b0, F1, "hlt_T1");
    push(3'd2, 1'b0, 15'h0, "hlt_T2");
    for (int k = 0; k < 20; k++) push(3'd2, 1'b1, 15'h0, $sformatf("hlt_hold%0d", k));
    opcode = 4'hF;
    repeat (23) @(posedge clk);
    #1 reset = 1'b1;
    #2;
    check("hlt_rst_halted", 32'(halted), 32'd0);
    check("hlt_rst_tstate", 32'(t_state), 32'd0);
    check("hlt_rst_ctrl", 32'(word_now()), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    run_vec(1);

    // Reset asserted mid-T3 of LDA, between clock edges.
    push(3'd0, 1'b0, F0, "lda_rst_T0");
    push(3'd1, 1'b0, F1, "lda_rst_T1");
    push(3'd2, 1'b0, C_EIR | C_LMAR, "lda_rst_T2");
    opcode = 4'h1;
    repeat (3) @(posedge clk);
    #1;
    check("lda_T3_load_a", 32'(load_a), 32'd1);
    check("lda_T3_oe_ram", 32'(oe_ram), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_load_a", 32'(load_a), 32'd0);
    check("async_oe_ram", 32'(oe_ram), 32'd0);
    check("async_tstate", 32'(t_state), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    run_vec(0);
    run_vec(3);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
